// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//
// Forwarding and load-use hazard unit sitting just upstream of the operand
// stage. A two-entry scoreboard remembers the destination of the instruction
// one ahead (result on alu_i) and two ahead (result on wb_i, or mem_i for a
// load). An instruction three ahead has written the write-before-read
// register file, so it needs no tracking.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   id_valid_i   instruction presented to the operand stage is valid
//   rs1_i/rs2_i  source register indices
//   rs1_used_i   instruction reads rs1
//   rs2_used_i   instruction reads rs2
//   rd_i         destination register index
//   rd_we_i      instruction writes rd
//   is_load_i    instruction is a load
//   flush_i      kill the instruction in the operand stage (taken branch/jump)
//   A1_sel_o     operand 1 select: 00 regfile, 01 alu_i, 10 wb_i, 11 mem_i
//   B1_sel_o     operand 2 select, same encoding
//   stall_o      hold PC/decode and insert a bubble (load-use)
//   stall_cnt_o  saturating count of stall cycles
// ---------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic              rs1_used_i,
  input  logic              rs2_used_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              rd_we_i,
  input  logic              is_load_i,
  input  logic              flush_i,
  output logic [1:0]        A1_sel_o,
  output logic [1:0]        B1_sel_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_ALU = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;
  localparam logic [1:0] SEL_MEM = 2'b11;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              we;  // already qualified with rd != x0
    logic              ld;
  } slot_t;

  slot_t            s1_q, s2_q;
  slot_t            s1_d;
  logic [CNT_W-1:0] cnt_q;

  logic s1_hit_rs1, s1_hit_rs2, s2_hit_rs1, s2_hit_rs2;

  // -------------------------------------------------------------------------
  // Hit detection against the registered slots
  // -------------------------------------------------------------------------
  assign s1_hit_rs1 = rs1_used_i & id_valid_i & s1_q.v & s1_q.we
                    & (s1_q.rd == rs1_i) & (rs1_i != '0);
  assign s1_hit_rs2 = rs2_used_i & id_valid_i & s1_q.v & s1_q.we
                    & (s1_q.rd == rs2_i) & (rs2_i != '0);
  assign s2_hit_rs1 = rs1_used_i & id_valid_i & s2_q.v & s2_q.we
                    & (s2_q.rd == rs1_i) & (rs1_i != '0);
  assign s2_hit_rs2 = rs2_used_i & id_valid_i & s2_q.v & s2_q.we
                    & (s2_q.rd == rs2_i) & (rs2_i != '0);

  // A load one ahead has no result yet: wait one cycle, after which the load
  // sits in S2 and its data is on mem_i. A flush kills the consumer, so there
  // is nothing to wait for.
  assign stall_o = (s1_hit_rs1 | s1_hit_rs2) & s1_q.ld & ~flush_i;

  // Youngest producer wins. An S1 load hit (only reachable under flush) falls
  // through to the S2 check.
  function automatic logic [1:0] fwd_sel(input logic hit1, input logic hit2);
    logic [1:0] sel;
    sel = SEL_RF;
    if (hit1 && !s1_q.ld) sel = SEL_ALU;
    else if (hit2)        sel = s2_q.ld ? SEL_MEM : SEL_WB;
    return sel;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    A1_sel_o = SEL_RF;
    B1_sel_o = SEL_RF;
    if (!stall_o) begin
      A1_sel_o = fwd_sel(s1_hit_rs1, s2_hit_rs1);
      B1_sel_o = fwd_sel(s1_hit_rs2, s2_hit_rs2);
    end
  end

  // -------------------------------------------------------------------------
  // Next S1 entry: a bubble whenever nothing real advances out of the stage
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later statements see the
    // value just computed; clocked blocks below use '<=' only.
    s1_d = '0;
    if (id_valid_i && !flush_i && !stall_o) begin
      s1_d.v  = 1'b1;
      s1_d.rd = rd_i;
      s1_d.we = rd_we_i & (rd_i != '0);
      s1_d.ld = is_load_i;
    end
  end

  // -------------------------------------------------------------------------
  // Scoreboard and stall counter
  // -------------------------------------------------------------------------
  // NOTE: the slots are control state (valid bits decide hazards), so they
  // take the asynchronous reset; there is no storage array here that would
  // be left unreset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      cnt_q <= '0;
    end else begin
      s2_q <= s1_q;
      s1_q <= s1_d;
      if (stall_o && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_unit
//
// Drives directed instruction sequences and then random traffic into
// fwd_hazard_unit. A behavioural model keeps a history of the instructions
// that actually entered the pipeline (youngest first) and derives the
// expected selects, stall and stall count from it. A second instance with a
// 3-bit counter exercises counter saturation.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_unit;

  localparam int SMALL_W   = 3;
  localparam int SMALL_MAX = (1 << SMALL_W) - 1;
  localparam int BIG_MAX   = (1 << 16) - 1;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  rs1, rs2, rd;
  logic        rs1_used, rs2_used, rd_we, is_load, flush;
  logic [1:0]  a_sel, b_sel, a_sel_s, b_sel_s;
  logic        stall, stall_s;
  logic [15:0] stall_cnt;
  logic [SMALL_W-1:0] stall_cnt_s;

  fwd_hazard_unit dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .rs1_i(rs1), .rs2_i(rs2),
    .rs1_used_i(rs1_used), .rs2_used_i(rs2_used), .rd_i(rd), .rd_we_i(rd_we),
    .is_load_i(is_load), .flush_i(flush), .A1_sel_o(a_sel), .B1_sel_o(b_sel),
    .stall_o(stall), .stall_cnt_o(stall_cnt)
  );

  fwd_hazard_unit #(.CNT_W(SMALL_W)) dut_small (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .rs1_i(rs1), .rs2_i(rs2),
    .rs1_used_i(rs1_used), .rs2_used_i(rs2_used), .rd_i(rd), .rd_we_i(rd_we),
    .is_load_i(is_load), .flush_i(flush), .A1_sel_o(a_sel_s), .B1_sel_o(b_sel_s),
    .stall_o(stall_s), .stall_cnt_o(stall_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: history of instructions that entered the pipeline,
  // hist[0] = one ahead, hist[1] = two ahead.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit acc;
    int rd;
    bit we;
    bit ld;
  } rec_t;

  rec_t hist[$];
  int   exp_cnt;
  int   exp_cnt_s;
  int   stalls_since_reset;

  function automatic bit writes(input int age, input int r);
    return hist[age].acc && hist[age].we && (hist[age].rd == r);
  endfunction

  function automatic bit model_stall();
    bit any = 0;
    if (id_valid && !flush) begin
      if (rs1_used && rs1 != 0 && writes(0, int'(rs1)) && hist[0].ld) any = 1;
      if (rs2_used && rs2 != 0 && writes(0, int'(rs2)) && hist[0].ld) any = 1;
    end
    return any;
  endfunction

  function automatic int model_sel(input bit used, input int r);
    if (!id_valid || !used || r == 0) return 0;
    if (model_stall())                return 0;
    if (writes(0, r) && !hist[0].ld)  return 1;
    if (writes(1, r))                 return hist[1].ld ? 3 : 2;
    return 0;
  endfunction

  task automatic model_clear();
    rec_t empty;
    empty = '{acc: 0, rd: 0, we: 0, ld: 0};
    hist.delete();
    hist.push_back(empty);
    hist.push_back(empty);
    exp_cnt = 0;
    exp_cnt_s = 0;
    stalls_since_reset = 0;
  endtask

  initial model_clear();

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_clear();
    end else begin
      rec_t nr;
      bit   st;
      st = model_stall();
      if (st) begin
        stalls_since_reset++;
        if (exp_cnt < BIG_MAX)     exp_cnt++;
        if (exp_cnt_s < SMALL_MAX) exp_cnt_s++;
      end
      nr.acc = id_valid && !flush && !st;
      nr.rd  = int'(rd);
      nr.we  = rd_we;
      nr.ld  = is_load;
      hist.push_front(nr);
      void'(hist.pop_back());
    end
  end

  // Compare process: outputs are combinational, so check mid-cycle.
  always @(negedge clk) begin
    if (chk_en && rst) begin
      check("stall",     int'(stall),       int'(model_stall()));
      check("a_sel",     int'(a_sel),       model_sel(rs1_used, int'(rs1)));
      check("b_sel",     int'(b_sel),       model_sel(rs2_used, int'(rs2)));
      check("stall_cnt", int'(stall_cnt),   exp_cnt);
      check("cnt_small", int'(stall_cnt_s), exp_cnt_s);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step(input bit v, input int r1, input int r2, input bit u1,
                      input bit u2, input int d, input bit we, input bit ld,
                      input bit fl);
    @(posedge clk);
    #1;
    id_valid = v;
    rs1      = r1[4:0];
    rs2      = r2[4:0];
    rs1_used = u1;
    rs2_used = u2;
    rd       = d[4:0];
    rd_we    = we;
    is_load  = ld;
    flush    = fl;
    @(negedge clk);
  endtask

  task automatic nop();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0;
    id_valid = 0; rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0;
    rd = 0; rd_we = 0; is_load = 0; flush = 0;
    #1;
    check("reset_a_sel", int'(a_sel), 0);
    check("reset_stall", int'(stall), 0);
    check("reset_cnt",   int'(stall_cnt), 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    chk_en = 1;

    // addi x5,x1 ; add x6,x5,x5 -> both from alu_i
    step(1, 1, 0, 1, 0, 5, 1, 0, 0);
    step(1, 5, 5, 1, 1, 6, 1, 0, 0);
    check("t1_a_sel", int'(a_sel), 1);
    check("t1_b_sel", int'(b_sel), 1);
    check("t1_stall", int'(stall), 0);

    // addi x5 ; nop ; sub x7,x5,x1 -> rs1 from wb_i
    step(1, 1, 0, 1, 0, 5, 1, 0, 0);
    nop();
    step(1, 5, 1, 1, 1, 7, 1, 0, 0);
    check("t2_a_sel", int'(a_sel), 2);
    check("t2_b_sel", int'(b_sel), 0);

    // lw x8,0(x2) ; add x9,x8,x2 -> one stall, then mem_i
    step(1, 2, 0, 1, 0, 8, 1, 1, 0);
    step(1, 8, 2, 1, 1, 9, 1, 0, 0);
    check("t3_stall",     int'(stall), 1);
    check("t3_cnt_before", int'(stall_cnt), 0);
    step(1, 8, 2, 1, 1, 9, 1, 0, 0);
    check("t3_stall_end", int'(stall), 0);
    check("t3_a_sel",     int'(a_sel), 3);
    check("t3_cnt_after", int'(stall_cnt), 1);

    // writes to x0 (alu and load) then read x0 -> nothing forwarded
    step(1, 1, 0, 1, 0, 0, 1, 0, 0);
    step(1, 1, 0, 1, 0, 0, 1, 1, 0);
    step(1, 0, 0, 1, 1, 4, 1, 0, 0);
    check("t4_a_sel", int'(a_sel), 0);
    check("t4_b_sel", int'(b_sel), 0);
    check("t4_stall", int'(stall), 0);

    // addi x3 ; lw x3 ; add x10,x3,x0 -> S1 load wins
    step(1, 1, 0, 1, 0, 3, 1, 0, 0);
    step(1, 1, 0, 1, 0, 3, 1, 1, 0);
    step(1, 3, 0, 1, 1, 10, 1, 0, 0);
    check("t5_stall", int'(stall), 1);
    step(1, 3, 0, 1, 1, 10, 1, 0, 0);
    check("t5_a_sel", int'(a_sel), 3);
    check("t5_cnt",   int'(stall_cnt), 2);

    // load-use with flush in the same cycle -> no stall, counter unchanged
    step(1, 1, 0, 1, 0, 11, 1, 1, 0);
    step(1, 11, 0, 1, 0, 12, 1, 0, 1);
    check("t6_stall", int'(stall), 0);
    nop();
    check("t6_cnt", int'(stall_cnt), 2);

    // reset asserted mid-stall drops everything asynchronously
    step(1, 1, 0, 1, 0, 13, 1, 1, 0);
    step(1, 13, 0, 1, 0, 14, 1, 0, 0);
    check("t7_stall_pre", int'(stall), 1);
    #2 rst = 1'b0;
    #1;
    check("t7_rst_stall", int'(stall), 0);
    check("t7_rst_a_sel", int'(a_sel), 0);
    check("t7_rst_b_sel", int'(b_sel), 0);
    check("t7_rst_cnt",   int'(stall_cnt), 0);
    #5 rst = 1'b1;
    step(1, 13, 0, 1, 0, 14, 1, 0, 0);
    check("t7_post_stall", int'(stall), 0);
    check("t7_post_a_sel", int'(a_sel), 0);

    // random traffic over a small register set so hazards are frequent
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99) < 85, $urandom_range(3), $urandom_range(3),
           $urandom_range(1), $urandom_range(1), $urandom_range(3),
           $urandom_range(99) < 80, $urandom_range(99) < 35,
           $urandom_range(99) < 10);
      if (i == 1500) begin
        #2 rst = 1'b0;
        #1;
        check("rand_rst_stall", int'(stall), 0);
        check("rand_rst_cnt",   int'(stall_cnt), 0);
        #3 rst = 1'b1;
      end
    end

    // narrow counter must have pinned at its maximum
    if (stalls_since_reset >= SMALL_MAX)
      check("small_cnt_saturated", int'(stall_cnt_s), SMALL_MAX);
    check("big_cnt_total", int'(stall_cnt), stalls_since_reset);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
